// File: rtl/dmem_store_buffer_pkg.sv
// dmem_store_buffer_pkg: shared defaults and buffered-store entry type for the data-memory store buffer
package dmem_store_buffer_pkg;
  localparam int SB_DATA_W = 32;
  localparam int SB_DEPTH  = 4;
  typedef struct packed {
    logic [SB_DATA_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_fifo.sv
// store_buffer_fifo: in-order store queue with occupancy tracking and youngest-match address search
module store_buffer_fifo
  import dmem_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  sb_entry_t            wr_entry,
  input  logic [SB_DATA_W-1:0] lookup_addr,
  output sb_entry_t            head,
  output logic                 empty,
  output logic                 full,
  output logic                 hit,
  output logic [SB_DATA_W-1:0] hit_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  sb_entry_t     mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [CW-1:0] count;
  assign head  = mem[head_ptr];
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
  // walk entries oldest to youngest so the last match seen is the youngest
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count && mem[head_ptr + PW'(k)].addr == lookup_addr) begin
        hit      = 1'b1;
        hit_data = mem[head_ptr + PW'(k)].data;
      end
    end
  end
  // entry storage needs no reset; occupancy decides which slots are live
  always_ff @(posedge clock) begin
    if (push) mem[tail_ptr] <= wr_entry;
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop) head_ptr <= head_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-write store buffer between memory stage and dmem; STORE_BUF_FWD_EN enables store-to-load forwarding
module dmem_store_buffer
  import dmem_store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_wren,
  input  logic              cpu_rden,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              mem_ready,
  output logic              sb_empty
);
  sb_entry_t         wr_entry;
  sb_entry_t         head;
  logic              empty;
  logic              full;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic              need_port;
  logic              fwd_stall;
  logic              push;
  logic              pop;
  assign wr_entry = '{addr: cpu_address, data: cpu_data};
  assign sb_empty = empty;
  store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .wr_entry    (wr_entry),
    .lookup_addr (cpu_address),
    .head        (head),
    .empty       (empty),
    .full        (full),
    .hit         (hit),
    .hit_data    (hit_data)
  );
`ifdef STORE_BUF_FWD_EN
  assign fwd_stall = 1'b0;
  assign cpu_q     = hit ? hit_data : mem_q;
`else
  logic fwd_unused;
  assign fwd_unused = ^hit_data;
  assign fwd_stall  = cpu_rden && hit;
  assign cpu_q      = mem_q;
`endif
  // a matching load never takes the port, so draining keeps going while it waits or forwards
  always_comb begin
    need_port   = cpu_rden && !hit;
    pop         = !reset && !empty && mem_ready && !need_port;
    cpu_stall   = !reset && ((need_port && !mem_ready) || fwd_stall || (cpu_wren && full && !pop));
    push        = cpu_wren && !cpu_stall;
    mem_wren    = pop;
    mem_address = pop ? head.addr : cpu_address;
    mem_data    = pop ? head.data : cpu_data;
  end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: directed scoreboard bench for dmem_store_buffer
module tb_dmem_store_buffer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_address = '0;
  logic [31:0] cpu_data = '0;
  logic        cpu_wren = 1'b0;
  logic        cpu_rden = 1'b0;
  logic [31:0] cpu_q;
  logic        cpu_stall;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q = 32'h1234_5678;
  logic        mem_ready = 1'b0;
  logic        sb_empty;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  bit          rnd = 1'b0;
  int          n;
  always #5 clock = ~clock;
  dmem_store_buffer dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_address (cpu_address),
    .cpu_data    (cpu_data),
    .cpu_wren    (cpu_wren),
    .cpu_rden    (cpu_rden),
    .cpu_q       (cpu_q),
    .cpu_stall   (cpu_stall),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q),
    .mem_ready   (mem_ready),
    .sb_empty    (sb_empty)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // every memory write must be the oldest outstanding expected store
  always @(negedge clock) begin
    if (!reset && mem_wren) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got %h<-%h expected none", mem_address, mem_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({mem_address, mem_data} !== e) begin
          errors++;
          $display("FAIL write_order: got %h<-%h expected %h<-%h", mem_address, mem_data, e[63:32], e[31:0]);
        end
      end
    end
  end
  always @(posedge clock) begin
    if (rnd) begin
      #1 mem_ready = 1'($urandom_range(0, 1));
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int stalls);
    cpu_address = a;
    cpu_data    = d;
    cpu_wren    = 1'b1;
    exp_q.push_back({a, d});
    stalls = 0;
    @(negedge clock);
    while (cpu_stall && stalls < 200) begin
      stalls++;
      @(negedge clock);
    end
    if (cpu_stall) chk("store_accept_timeout", 32'(cpu_stall), 32'd0);
    @(posedge clock);
    #1 cpu_wren = 1'b0;
  endtask
  task automatic wait_empty(input string name);
    int k;
    k = 0;
    @(negedge clock);
    while (!sb_empty && k < 200) begin
      k++;
      @(negedge clock);
    end
    chk(name, 32'(sb_empty), 32'd1);
    @(posedge clock);
    #1;
  endtask
  initial begin
    int s;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_empty", 32'(sb_empty), 32'd1);
    chk("reset_wren", 32'(mem_wren), 32'd0);
    chk("reset_stall", 32'(cpu_stall), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    // single store drains the next cycle
    mem_ready = 1'b1;
    do_store(32'h10, 32'hAAAA, s);
    chk("t1_stalls", 32'(s), 32'd0);
    @(negedge clock);
    chk("t1_wren", 32'(mem_wren), 32'd1);
    chk("t1_addr", mem_address, 32'h10);
    chk("t1_data", mem_data, 32'hAAAA);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("t1_empty_after", 32'(sb_empty), 32'd1);
    @(posedge clock);
    #1;
    // fill to DEPTH, then simultaneous push and pop at full
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_store(32'(i), 32'h100 + 32'(i), s);
      chk("t2_fill_stalls", 32'(s), 32'd0);
    end
    cpu_address = 32'h4;
    cpu_data    = 32'h104;
    cpu_wren    = 1'b1;
    exp_q.push_back({32'h4, 32'h104});
    @(negedge clock);
    chk("t2_full_stall", 32'(cpu_stall), 32'd1);
    chk("t2_full_no_wren", 32'(mem_wren), 32'd0);
    @(posedge clock);
    #1 mem_ready = 1'b1;
    @(negedge clock);
    chk("t2_pushpop_stall", 32'(cpu_stall), 32'd0);
    chk("t2_pushpop_wren", 32'(mem_wren), 32'd1);
    chk("t2_pushpop_addr", mem_address, 32'h0);
    @(posedge clock);
    #1 cpu_wren = 1'b0;
    wait_empty("t2_drain");
    // two stores to the same address, then a matching load
    mem_ready = 1'b0;
    do_store(32'h20, 32'h1, s);
    do_store(32'h20, 32'h2, s);
    cpu_rden    = 1'b1;
    cpu_address = 32'h20;
    mem_q       = 32'h55;
`ifdef STORE_BUF_FWD_EN
    @(negedge clock);
    chk("t3_fwd_stall", 32'(cpu_stall), 32'd0);
    chk("t3_fwd_q", cpu_q, 32'h2);
    @(posedge clock);
    #1 cpu_rden = 1'b0;
    mem_ready = 1'b1;
    wait_empty("t3_fwd_drain");
`else
    @(negedge clock);
    chk("t3_match_stall", 32'(cpu_stall), 32'd1);
    @(posedge clock);
    #1 mem_ready = 1'b1;
    mem_q = 32'h2;
    n = 0;
    @(negedge clock);
    while (cpu_stall && n < 50) begin
      n++;
      @(negedge clock);
    end
    chk("t3_stall_cycles", 32'(n), 32'd2);
    chk("t3_load_q", cpu_q, 32'h2);
    chk("t3_load_addr", mem_address, 32'h20);
    chk("t3_load_wren", 32'(mem_wren), 32'd0);
    chk("t3_empty", 32'(sb_empty), 32'd1);
    @(posedge clock);
    #1 cpu_rden = 1'b0;
`endif
    // non-matching load takes the port over draining
    mem_ready = 1'b0;
    do_store(32'h30, 32'h7, s);
    do_store(32'h31, 32'h8, s);
    cpu_rden    = 1'b1;
    cpu_address = 32'h40;
    mem_q       = 32'h99;
    @(negedge clock);
    chk("t4_load_busy_stall", 32'(cpu_stall), 32'd1);
    @(posedge clock);
    #1 mem_ready = 1'b1;
    @(negedge clock);
    chk("t4_load_stall", 32'(cpu_stall), 32'd0);
    chk("t4_load_addr", mem_address, 32'h40);
    chk("t4_load_wren", 32'(mem_wren), 32'd0);
    chk("t4_load_q", cpu_q, 32'h99);
    chk("t4_not_empty", 32'(sb_empty), 32'd0);
    @(posedge clock);
    #1 cpu_rden = 1'b0;
    @(negedge clock);
    chk("t4_resume_wren", 32'(mem_wren), 32'd1);
    chk("t4_resume_addr", mem_address, 32'h30);
    @(posedge clock);
    #1;
    wait_empty("t4_drain");
    // reset discards buffered stores
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_store(32'h50 + 32'(i), 32'hB0 + 32'(i), s);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    chk("t5_reset_wren", 32'(mem_wren), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    mem_ready = 1'b1;
    @(negedge clock);
    chk("t5_empty", 32'(sb_empty), 32'd1);
    chk("t5_wren", 32'(mem_wren), 32'd0);
    repeat (5) @(posedge clock);
    #1;
    // ten stores with random ready across pointer wrap
    rnd = 1'b1;
    for (int i = 0; i < 10; i++) do_store(32'h60 + 32'(i), 32'hC000 + 32'(i), s);
    wait_empty("t6_drain");
    rnd = 1'b0;
    @(posedge clock);
    #2 mem_ready = 1'b1;
    @(negedge clock);
    chk("t6_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
